// File: rtl/logic_ou_buffered_if.sv
`timescale 1ns/1ps
// Operand, result and (tied-off) LSQ signals of one OU slot.
// slave = the operation unit, master = the surrounding fabric / bench.
interface logic_ou_buffered_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic             data_valid_in1;
    logic             data_valid_in2;
    logic             data_in_ack1;
    logic             data_in_ack2;
    logic             uses_data_in1;
    logic             uses_data_in2;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic             data_out_ack;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
    logic [2:0]       fn3;
    logic             load;
    logic             store;
    logic             new_request;
    logic             lsq_full;
    logic [WIDTH-1:0] load_data;
    logic             load_complete;

    modport slave (
        input  data_in1, data_in2, data_valid_in1, data_valid_in2, data_out_ack,
               lsq_full, load_data, load_complete,
        output data_in_ack1, data_in_ack2, uses_data_in1, uses_data_in2,
               data_out, data_valid_out, addr, data, fn3, load, store, new_request
    );

    modport master (
        output data_in1, data_in2, data_valid_in1, data_valid_in2, data_out_ack,
               lsq_full, load_data, load_complete,
        input  data_in_ack1, data_in_ack2, uses_data_in1, uses_data_in2,
               data_out, data_valid_out, addr, data, fn3, load, store, new_request
    );
endinterface

// File: rtl/logic_ou_buffered.sv
`timescale 1ns/1ps
// Bitwise-logic OU with per-operand FIFOs and a registered result.
// Latency: operand ack in cycle N -> data_valid_out in cycle N+2; 1 result/cycle sustained.
// Backpressure: a held result stops FIFO pops; a full FIFO withholds its ack (no pass-through).

module logic_ou_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module logic_ou_buffered #(
    parameter int               WIDTH      = 32,
    parameter int               FIFO_DEPTH = 2,
    parameter int               OP         = 0,
    parameter int               USE_CONST2 = 0,
    parameter logic [WIDTH-1:0] CONST2     = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    logic_ou_buffered_if.slave ou
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam bit          CONST_OP2 = (USE_CONST2 != 0);

    if (OP < 0 || OP > 3) begin : g_bad_op
        $error("logic_ou_buffered: OP=%0d is not a supported operation", OP);
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("logic_ou_buffered: FIFO_DEPTH=%0d must be a power of 2 and >= 2", FIFO_DEPTH);
    end

    logic [PW:0]      count1, count2;
    logic [WIDTH-1:0] head1, head2, op2, result;
    logic             push1, push2, pop1, pop2;
    logic             head2_valid, out_free, fire;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_out_q, data_valid_out_d;

    // Ack looks only at the current count, so a full FIFO stays unacked even while popping.
    assign push1 = ou.data_valid_in1 && (count1 < DEPTH_C);
    assign push2 = !CONST_OP2 && ou.data_valid_in2 && (count2 < DEPTH_C);

    logic_ou_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .push_dat (ou.data_in1),
        .pop      (pop1),
        .head_dat (head1),
        .count    (count1)
    );

    logic_ou_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push2),
        .push_dat (ou.data_in2),
        .pop      (pop2),
        .head_dat (head2),
        .count    (count2)
    );

    assign head2_valid = CONST_OP2 || (count2 != '0);
    assign op2         = CONST_OP2 ? CONST2 : head2;
    assign out_free    = !data_valid_out_q || ou.data_out_ack;
    assign fire        = (count1 != '0) && head2_valid && out_free;
    assign pop1        = fire;
    assign pop2        = fire && !CONST_OP2;

    always_comb begin
        result = head1 & ~op2;
        case (OP)
            0:       result = head1 & op2;
            1:       result = head1 | op2;
            2:       result = head1 ^ op2;
            default: result = head1 & ~op2;
        endcase
    end

    always_comb begin
        data_out_d       = data_out_q;
        data_valid_out_d = data_valid_out_q;
        if (fire) begin
            data_out_d       = result;
            data_valid_out_d = 1'b1;
        end else if (ou.data_out_ack) begin
            data_valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q       <= '0;
            data_valid_out_q <= 1'b0;
        end else begin
            data_out_q       <= data_out_d;
            data_valid_out_q <= data_valid_out_d;
        end
    end

    assign ou.data_out       = data_out_q;
    assign ou.data_valid_out = data_valid_out_q;
    assign ou.data_in_ack1   = push1;
    assign ou.data_in_ack2   = push2;
    assign ou.uses_data_in1  = 1'b1;
    assign ou.uses_data_in2  = !CONST_OP2;

    // This slot never issues memory requests.
    assign ou.addr        = '0;
    assign ou.data        = '0;
    assign ou.fn3         = '0;
    assign ou.load        = 1'b0;
    assign ou.store       = 1'b0;
    assign ou.new_request = 1'b0;

    logic unused_lsq;
    assign unused_lsq = ^{ou.lsq_full, ou.load_data, ou.load_complete};
endmodule

// File: tb/tb_logic_ou_buffered.sv
`timescale 1ns/1ps
// Bench for logic_ou_buffered: XOR instance with a result scoreboard,
// plus AND and constant-operand ANDN instances checked directly.
module tb_logic_ou_buffered;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_ou_buffered_if #(.WIDTH(W)) if0 ();
    logic_ou_buffered_if #(.WIDTH(W)) if1 ();
    logic_ou_buffered_if #(.WIDTH(W)) if2 ();

    logic_ou_buffered #(.WIDTH(W), .FIFO_DEPTH(2), .OP(2), .USE_CONST2(0), .CONST2(32'h0))
        u_xor (.clk(clk), .rst_n(rst_n), .ou(if0));
    logic_ou_buffered #(.WIDTH(W), .FIFO_DEPTH(2), .OP(0), .USE_CONST2(0), .CONST2(32'h0))
        u_and (.clk(clk), .rst_n(rst_n), .ou(if1));
    logic_ou_buffered #(.WIDTH(W), .FIFO_DEPTH(2), .OP(3), .USE_CONST2(1), .CONST2(32'h0000_FFFF))
        u_cst (.clk(clk), .rst_n(rst_n), .ou(if2));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [W-1:0] sb[$];
    int res_cyc[$];
    logic [W-1:0] a, b, held;
    logic [W-1:0] va[3], vx[3];
    int t0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard: every result the XOR unit hands over must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && if0.data_valid_out && if0.data_out_ack) begin
            res_cyc.push_back(cyc);
            if (sb.size() == 0) chk("spurious_result", W'(if0.data_valid_out), W'(0));
            else chk("result", if0.data_out, sb.pop_front());
        end
    end

    task automatic send1(input logic [W-1:0] v);
        int n = 0;
        if0.data_in1 = v;
        if0.data_valid_in1 = 1'b1;
        @(negedge clk);
        while (!if0.data_in_ack1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send1_timeout", W'(if0.data_in_ack1), W'(1));
        @(posedge clk); #1;
        if0.data_valid_in1 = 1'b0;
    endtask

    task automatic send2(input logic [W-1:0] v);
        int n = 0;
        if0.data_in2 = v;
        if0.data_valid_in2 = 1'b1;
        @(negedge clk);
        while (!if0.data_in_ack2 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send2_timeout", W'(if0.data_in_ack2), W'(1));
        @(posedge clk); #1;
        if0.data_valid_in2 = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk(tag, W'(sb.size()), W'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        if0.data_in1 = '0; if0.data_in2 = '0; if0.data_valid_in1 = 0; if0.data_valid_in2 = 0;
        if0.data_out_ack = 0; if0.lsq_full = 0; if0.load_data = '0; if0.load_complete = 0;
        if1.data_in1 = '0; if1.data_in2 = '0; if1.data_valid_in1 = 0; if1.data_valid_in2 = 0;
        if1.data_out_ack = 0; if1.lsq_full = 0; if1.load_data = '0; if1.load_complete = 0;
        if2.data_in1 = '0; if2.data_in2 = '0; if2.data_valid_in1 = 0; if2.data_valid_in2 = 0;
        if2.data_out_ack = 0; if2.lsq_full = 0; if2.load_data = '0; if2.load_complete = 0;

        // Reset state
        #12;
        chk("rst_vld", W'(if0.data_valid_out), W'(0));
        chk("rst_dat", if0.data_out, W'(0));
        chk("rst_ack1", W'(if0.data_in_ack1), W'(0));
        chk("rst_ack2", W'(if0.data_in_ack2), W'(0));
        chk("lsq_zero", if0.addr | if0.data | W'(if0.fn3) |
            W'({if0.load, if0.store, if0.new_request}), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AND, single pair: result in cycle 2 for one cycle
        if1.data_out_ack = 1;
        if1.data_in1 = 32'hF0F0_F0F0; if1.data_in2 = 32'hFF00_FF00;
        if1.data_valid_in1 = 1; if1.data_valid_in2 = 1;
        @(negedge clk);
        chk("t1_ack1", W'(if1.data_in_ack1), W'(1));
        chk("t1_ack2", W'(if1.data_in_ack2), W'(1));
        chk("t1_vld_c0", W'(if1.data_valid_out), W'(0));
        @(posedge clk); #1;
        if1.data_valid_in1 = 0; if1.data_valid_in2 = 0;
        @(negedge clk);
        chk("t1_vld_c1", W'(if1.data_valid_out), W'(0));
        @(negedge clk);
        chk("t1_vld_c2", W'(if1.data_valid_out), W'(1));
        chk("t1_dat", if1.data_out, 32'hF000_F000);
        @(negedge clk);
        chk("t1_vld_c3", W'(if1.data_valid_out), W'(0));
        @(posedge clk); #1;

        // Constant operand 2 with ANDN; input 2 must never be acked
        chk("t5_uses1", W'(if2.uses_data_in1), W'(1));
        chk("t5_uses2", W'(if2.uses_data_in2), W'(0));
        chk("t5_uses2_xor", W'(if0.uses_data_in2), W'(1));
        if2.data_out_ack = 1;
        if2.data_in1 = 32'h1234_5678; if2.data_valid_in1 = 1;
        if2.data_in2 = 32'hDEAD_BEEF; if2.data_valid_in2 = 1;
        @(negedge clk);
        chk("t5_ack1", W'(if2.data_in_ack1), W'(1));
        chk("t5_ack2_c0", W'(if2.data_in_ack2), W'(0));
        @(posedge clk); #1;
        if2.data_valid_in1 = 0;
        @(negedge clk);
        chk("t5_ack2_c1", W'(if2.data_in_ack2), W'(0));
        @(negedge clk);
        chk("t5_vld", W'(if2.data_valid_out), W'(1));
        chk("t5_dat", if2.data_out, 32'h1234_0000);
        chk("t5_ack2_c2", W'(if2.data_in_ack2), W'(0));
        @(posedge clk); #1;
        if2.data_valid_in2 = 0;

        // XOR, 4 back-to-back pairs: acks never drop, results in cycles 2..5
        if0.data_out_ack = 1;
        res_cyc.delete();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            if0.data_in1 = a; if0.data_in2 = b;
            if0.data_valid_in1 = 1; if0.data_valid_in2 = 1;
            sb.push_back(a ^ b);
            @(negedge clk);
            chk($sformatf("t2_ack1_%0d", i), W'(if0.data_in_ack1), W'(1));
            chk($sformatf("t2_ack2_%0d", i), W'(if0.data_in_ack2), W'(1));
            @(posedge clk); #1;
        end
        if0.data_valid_in1 = 0; if0.data_valid_in2 = 0;
        drain("t2_drain");
        chk("t2_count", W'(res_cyc.size()), W'(4));
        for (int i = 0; i < 4 && i < res_cyc.size(); i++)
            chk($sformatf("t2_cyc_%0d", i), W'(res_cyc[i]), W'(t0 + 2 + i));

        // Back-pressure: 1 held + 2 buffered per side, then acks drop
        if0.data_out_ack = 0;
        res_cyc.delete();
        held = '0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            if0.data_in1 = a; if0.data_in2 = b;
            if0.data_valid_in1 = 1; if0.data_valid_in2 = 1;
            sb.push_back(a ^ b);
            if (i == 0) held = a ^ b;
            @(negedge clk);
            chk($sformatf("t3_ack1_%0d", i), W'(if0.data_in_ack1), W'(i < 3));
            chk($sformatf("t3_ack2_%0d", i), W'(if0.data_in_ack2), W'(i < 3));
            if (i < 3) begin @(posedge clk); #1; end
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("t3_hold_vld", W'(if0.data_valid_out), W'(1));
            chk("t3_hold_dat", if0.data_out, held);
            chk("t3_stall_ack1", W'(if0.data_in_ack1), W'(0));
        end
        @(posedge clk); #1;
        if0.data_out_ack = 1;
        begin
            int n = 0;
            @(negedge clk);
            chk("t3_full_no_passthru", W'(if0.data_in_ack1), W'(0));
            while (!(if0.data_in_ack1 && if0.data_in_ack2) && n < 20) begin @(negedge clk); n++; end
            chk("t3_late_ack", W'(if0.data_in_ack1 && if0.data_in_ack2), W'(1));
        end
        @(posedge clk); #1;
        if0.data_valid_in1 = 0; if0.data_valid_in2 = 0;
        drain("t3_drain");
        chk("t3_count", W'(res_cyc.size()), W'(4));

        // Skewed arrival: in1 from cycle 0, in2 from cycle 5 -> results from cycle 7
        res_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            va[i] = $urandom; vx[i] = $urandom;
            sb.push_back(va[i] ^ vx[i]);
        end
        t0 = cyc;
        fork
            begin
                for (int i = 0; i < 3; i++) send1(va[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                for (int k = 0; k < 3; k++) send2(vx[k]);
            end
        join
        drain("t4_drain");
        chk("t4_count", W'(res_cyc.size()), W'(3));
        for (int i = 0; i < 3 && i < res_cyc.size(); i++)
            chk($sformatf("t4_cyc_%0d", i), W'(res_cyc[i]), W'(t0 + 7 + i));

        // Async reset with buffered operands and a pending result
        if0.data_out_ack = 0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            if0.data_in1 = a; if0.data_in2 = b;
            if0.data_valid_in1 = 1; if0.data_valid_in2 = 1;
            sb.push_back(a ^ b);
            @(negedge clk);
            chk($sformatf("t6_ack_%0d", i), W'(if0.data_in_ack1 && if0.data_in_ack2), W'(1));
            @(posedge clk); #1;
        end
        if0.data_valid_in1 = 0; if0.data_valid_in2 = 0;
        @(negedge clk);
        chk("t6_pre_vld", W'(if0.data_valid_out), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", W'(if0.data_valid_out), W'(0));
        chk("t6_rst_dat", if0.data_out, W'(0));
        sb.delete();
        res_cyc.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        if0.data_out_ack = 1;
        repeat (5) @(negedge clk);
        chk("t6_no_stale", W'(res_cyc.size()), W'(0));
        @(posedge clk); #1;
        a = 32'hA5A5_0F0F; b = 32'h0FF0_FFFF;
        sb.push_back(32'hAA55_F0F0);
        fork
            send1(a);
            send2(b);
        join
        drain("t6_drain");
        chk("t6_count", W'(res_cyc.size()), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
